// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port
// indices and default bus widths.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    localparam int PORT_CPU = 0;
    localparam int PORT_LDR = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDATA  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester + data-memory bundle for dmem_arbiter.
// slave  : the arbiter's view (requests and mem_rdata in, grants/memory bus out)
// master : the environment's view (requesters and the memory model)
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [1:0]        req;
    logic [1:0]        req_we;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_rdata,
        output gnt, rvalid, rdata, busy, mem_re, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_rdata,
        input  gnt, rvalid, rdata, busy, mem_re, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way combinational pick. Round-robin under contention by default;
// fixed CPU priority when DMEM_ARB_CPU_PRIO_EN is defined.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       any_req,
    output logic       winner
);

`ifdef DMEM_ARB_CPU_PRIO_EN
    // history is irrelevant in fixed-priority mode
    logic unused_last_gnt_s;
    assign unused_last_gnt_s = last_gnt;
`endif

    // pick the winning port index from the current requests
    always_comb begin
        any_req = |req;
        winner  = 1'(PORT_CPU);
        if (req == 2'b11) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
            winner = 1'(PORT_CPU);
`else
            winner = ~last_gnt;
`endif
        end else if (req == 2'b10) begin
            winner = 1'(PORT_LDR);
        end else begin
            winner = 1'(PORT_CPU);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one memory (registered one-cycle read)
// between the processor (port 0) and the loader/debug master (port 1).
// Optional build macro: DMEM_ARB_CPU_PRIO_EN (fixed CPU priority).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    arb_state_t        state_r, state_n;
    logic [1:0]        gnt_r, gnt_n;
    logic [1:0]        rvalid_r, rvalid_n;
    logic [DATA_W-1:0] rdata_r, rdata_n;
    logic              busy_r, busy_n;
    logic              mem_re_r, mem_re_n;
    logic              mem_we_r, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_n;
    logic              last_gnt_r, last_gnt_n;
    logic              cap_win_r, cap_win_n;
    logic              any_req_s;
    logic              win_s;

    rr_arb2 u_arb (
        .req      (bus.req),
        .last_gnt (last_gnt_r),
        .any_req  (any_req_s),
        .winner   (win_s)
    );

    // next-state and next-output decode; memory bus values are computed one
    // cycle ahead so every output comes straight from a flop
    always_comb begin
        state_n     = state_r;
        gnt_n       = 2'b00;
        rvalid_n    = 2'b00;
        rdata_n     = rdata_r;
        mem_re_n    = 1'b0;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr_r;
        mem_wdata_n = mem_wdata_r;
        last_gnt_n  = last_gnt_r;
        cap_win_n   = cap_win_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_n        = ST_ACCESS;
                    gnt_n[win_s]   = 1'b1;
                    last_gnt_n     = win_s;
                    cap_win_n      = win_s;
                    mem_we_n       = bus.req_we[win_s];
                    mem_re_n       = ~bus.req_we[win_s];
                    if (win_s == 1'(PORT_LDR)) begin
                        mem_addr_n  = bus.req_addr1;
                        mem_wdata_n = bus.req_wdata1;
                    end else begin
                        mem_addr_n  = bus.req_addr0;
                        mem_wdata_n = bus.req_wdata0;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // the registered write enable still holds the captured direction
                if (mem_we_r) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_RDATA;
                end
            end
            ST_RDATA: begin
                rdata_n             = bus.mem_rdata;
                rvalid_n[cap_win_r] = 1'b1;
                state_n             = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    // state and output registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            gnt_r       <= 2'b00;
            rvalid_r    <= 2'b00;
            rdata_r     <= '0;
            busy_r      <= 1'b0;
            mem_re_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            last_gnt_r  <= 1'b1;
            cap_win_r   <= 1'b0;
        end else begin
            state_r     <= state_n;
            gnt_r       <= gnt_n;
            rvalid_r    <= rvalid_n;
            rdata_r     <= rdata_n;
            busy_r      <= busy_n;
            mem_re_r    <= mem_re_n;
            mem_we_r    <= mem_we_n;
            mem_addr_r  <= mem_addr_n;
            mem_wdata_r <= mem_wdata_n;
            last_gnt_r  <= last_gnt_n;
            cap_win_r   <= cap_win_n;
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.rvalid    = rvalid_r;
    assign bus.rdata     = rdata_r;
    assign bus.busy      = busy_r;
    assign bus.mem_re    = mem_re_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected grants,
// memory accesses and read returns (with their cycle numbers) into queues;
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_dmem_arbiter;

    typedef struct {
        int          cyc;
        logic [1:0]  v;
        logic [15:0] d;
    } ev_t;

    typedef struct {
        int          cyc;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } mem_ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    ev_t     gnt_q[$];
    ev_t     rv_q[$];
    mem_ev_t mem_q[$];

    logic [15:0] mem [256];

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    dmem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // memory model with registered one-cycle read
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re === 1'b1) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: compare every grant, memory access and read return
    always @(negedge clk) begin
        ev_t     e;
        mem_ev_t m;
        if (bus.gnt !== 2'b00 && !$isunknown(bus.gnt)) begin
            if (gnt_q.size() == 0) begin
                check("gnt_unexpected", {30'd0, bus.gnt}, 32'd0);
            end else begin
                e = gnt_q.pop_front();
                check("gnt_cycle", cyc, e.cyc);
                check("gnt_value", {30'd0, bus.gnt}, {30'd0, e.v});
            end
        end
        if (bus.rvalid !== 2'b00 && !$isunknown(bus.rvalid)) begin
            if (rv_q.size() == 0) begin
                check("rvalid_unexpected", {30'd0, bus.rvalid}, 32'd0);
            end else begin
                e = rv_q.pop_front();
                check("rvalid_cycle", cyc, e.cyc);
                check("rvalid_value", {30'd0, bus.rvalid}, {30'd0, e.v});
                check("rdata_value", {16'd0, bus.rdata}, {16'd0, e.d});
            end
        end
        if (bus.mem_re === 1'b1 || bus.mem_we === 1'b1) begin
            if (mem_q.size() == 0) begin
                check("mem_unexpected", {30'd0, bus.mem_re, bus.mem_we}, 32'd0);
            end else begin
                m = mem_q.pop_front();
                check("mem_cycle", cyc, m.cyc);
                check("mem_en", {30'd0, bus.mem_re, bus.mem_we}, {30'd0, ~m.we, m.we});
                check("mem_addr", {24'd0, bus.mem_addr}, {24'd0, m.addr});
                if (m.we) check("mem_wdata", {16'd0, bus.mem_wdata}, {16'd0, m.wdata});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic we, input logic [7:0] a, input logic [15:0] d);
        bus.req[p]    = 1'b1;
        bus.req_we[p] = we;
        if (p == 0) begin
            bus.req_addr0  = a;
            bus.req_wdata0 = d;
        end else begin
            bus.req_addr1  = a;
            bus.req_wdata1 = d;
        end
    endtask

    task automatic expect_access(input int k, input int p, input logic we,
                                 input logic [7:0] a, input logic [15:0] d);
        gnt_q.push_back('{cyc: k + 1, v: (p == 1) ? 2'b10 : 2'b01, d: 16'h0000});
        mem_q.push_back('{cyc: k + 1, we: we, addr: a, wdata: d});
        if (!we) rv_q.push_back('{cyc: k + 3, v: (p == 1) ? 2'b10 : 2'b01, d: mem_exp(a)});
    endtask

    // hand-maintained expected memory contents
    logic [15:0] exp_mem [256];
    function automatic logic [15:0] mem_exp(input logic [7:0] a);
        return exp_mem[a];
    endfunction

    initial begin
        int k;
        int p;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'h0000;
            exp_mem[i] = 16'h0000;
        end
        mem[8'h20] = 16'h1111;  exp_mem[8'h20] = 16'h1111;
        mem[8'h30] = 16'h2222;  exp_mem[8'h30] = 16'h2222;
        bus.req = 2'b00;  bus.req_we = 2'b00;
        bus.req_addr0 = 8'h00;  bus.req_addr1 = 8'h00;
        bus.req_wdata0 = 16'h0000;  bus.req_wdata1 = 16'h0000;
        bus.mem_rdata = 16'h0000;

        // reset, then idle with no requests
        tick(3);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("idle_busy", {31'd0, bus.busy}, 32'd0);
            check("idle_ctrl", {26'd0, bus.gnt, bus.rvalid, bus.mem_re, bus.mem_we}, 32'd0);
        end
        check("idle_data", {bus.rdata, bus.mem_wdata}, 32'd0);
        check("idle_addr", {24'd0, bus.mem_addr}, 32'd0);

        // port 0 write 0x10 <- 0xBEEF
        k = cyc;
        exp_mem[8'h10] = 16'hBEEF;
        expect_access(k, 0, 1'b1, 8'h10, 16'hBEEF);
        drive(0, 1'b1, 8'h10, 16'hBEEF);
        tick(1);
        check("wr_busy_access", {31'd0, bus.busy}, 32'd1);
        bus.req = 2'b00;
        tick(1);
        check("wr_back_idle", {31'd0, bus.busy}, 32'd0);

        // port 1 read of 0x10
        k = cyc;
        expect_access(k, 1, 1'b0, 8'h10, 16'h0000);
        drive(1, 1'b0, 8'h10, 16'h0000);
        tick(1);
        bus.req = 2'b00;
        tick(3);

        // both ports request reads continuously
        k = cyc;
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
            p = 0;
`else
            p = i % 2;
`endif
            expect_access(k + 3 * i, p, 1'b0, (p == 1) ? 8'h30 : 8'h20, 16'h0000);
        end
        drive(0, 1'b0, 8'h20, 16'h0000);
        drive(1, 1'b0, 8'h30, 16'h0000);
        tick(10);
        bus.req = 2'b00;
        tick(4);

        // reset while a read sits in RDATA: the read is dropped
        k = cyc;
        gnt_q.push_back('{cyc: k + 1, v: 2'b01, d: 16'h0000});
        mem_q.push_back('{cyc: k + 1, we: 1'b0, addr: 8'h20, wdata: 16'h0000});
        drive(0, 1'b0, 8'h20, 16'h0000);
        tick(1);
        bus.req = 2'b00;
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rst_rdata", {16'd0, bus.rdata}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        tick(3);

        // service resumes after the abort: port 1 write then read back
        k = cyc;
        exp_mem[8'h40] = 16'h1234;
        expect_access(k, 1, 1'b1, 8'h40, 16'h1234);
        drive(1, 1'b1, 8'h40, 16'h1234);
        tick(1);
        bus.req = 2'b00;
        tick(1);
        k = cyc;
        expect_access(k, 1, 1'b0, 8'h40, 16'h0000);
        drive(1, 1'b0, 8'h40, 16'h0000);
        tick(1);
        bus.req = 2'b00;
        tick(3);

        // req dropped in the grant cycle, reasserted by port 0 in cycle 2
        k = cyc;
        exp_mem[8'h50] = 16'hA5A5;
        exp_mem[8'h52] = 16'h5A5A;
        expect_access(k, 0, 1'b1, 8'h50, 16'hA5A5);
        expect_access(k + 2, 0, 1'b1, 8'h52, 16'h5A5A);
        drive(0, 1'b1, 8'h50, 16'hA5A5);
        tick(1);
        bus.req = 2'b00;
        tick(1);
        drive(0, 1'b1, 8'h52, 16'h5A5A);
        tick(1);
        bus.req = 2'b00;
        tick(1);
        k = cyc;
        expect_access(k, 0, 1'b0, 8'h52, 16'h0000);
        drive(0, 1'b0, 8'h52, 16'h0000);
        tick(1);
        bus.req = 2'b00;
        tick(5);

        check("gnt_q_left", gnt_q.size(), 32'd0);
        check("rv_q_left", rv_q.size(), 32'd0);
        check("mem_q_left", mem_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
